// File: rtl/prd_bus_pkg.sv
// prd_bus_pkg: shared op, register and state encodings for the backplane poll master
package prd_bus_pkg;
  typedef enum logic [2:0] {OP_RD_COM0, OP_RD_COM1, OP_RD_ID, OP_WR_IND, OP_WR_TEST} op_t;
  localparam logic [1:0] REG_COM0 = 2'b00;
  localparam logic [1:0] REG_COM1 = 2'b01;
  localparam logic [1:0] REG_IND  = 2'b10;
  localparam logic [1:0] REG_ID   = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  typedef enum logic [1:0] {P_IDLE, P_ACCESS, P_NEXT} poll_t;
  // Each command byte carries its nibble twice, the upper copy inverted
  function automatic logic [4:0] dec_byte(input logic [7:0] b);
    return {b[7:4] == ~b[3:0], b[3:0]};
  endfunction
  function automatic logic [1:0] op_addr(input op_t op);
    return op == OP_RD_COM0 ? REG_COM0 : op == OP_RD_COM1 ? REG_COM1 : op == OP_WR_IND ? REG_IND : REG_ID;
  endfunction
endpackage

// File: rtl/prd_poll_ctrl_if.sv
// prd_poll_ctrl_if: backplane bus between the poll master and the command-input boards
interface prd_poll_ctrl_if;
  logic [1:0] oA;
  logic [3:0] oCS;
  logic oRd;
  logic oWr;
  logic [15:0] bd_out;
  logic bd_oe;
  logic [15:0] slv_out;
  logic slv_oe;
  wire [15:0] bD;
  assign bD = bd_oe ? bd_out : 16'hzzzz;
  assign bD = slv_oe ? slv_out : 16'hzzzz;
  modport master (output oA, oCS, oRd, oWr, bd_out, bd_oe, input bD);
  modport slave (input oA, oCS, oRd, oWr, bD, output slv_out, slv_oe);
endinterface

// File: rtl/prd_bus_access.sv
// prd_bus_access: one backplane read or write access (setup, strobe, hold) with tristate data
module prd_bus_access import prd_bus_pkg::*; #(
  parameter int STROBE_CLK = 2,
  parameter logic [3:0] CS_IDLE = 4'b0000
) (
  input logic clk,
  input logic iRes,
  input logic start,
  input logic wr,
  input logic [1:0] addr,
  input logic [3:0] cs,
  input logic [15:0] wdata,
  output logic done,
  output logic [15:0] rdata,
  prd_poll_ctrl_if.master bus
);
  localparam int CW = $clog2(STROBE_CLK + 1);
  state_t st, st_nxt;
  logic [CW-1:0] cnt;
  logic last;
  logic wr_q;
  logic [1:0] a_q;
  logic [3:0] cs_q;
  logic [15:0] wd_q;
  assign last = cnt == CW'(STROBE_CLK - 1);
  always_comb begin
    st_nxt = st;
    st_nxt = st == S_IDLE ? (start ? S_SETUP : S_IDLE) : st == S_SETUP ? S_STROBE :
             st == S_STROBE ? (last ? S_HOLD : S_STROBE) : S_IDLE;
  end
  always_ff @(posedge clk or negedge iRes)
    if (!iRes) begin
      st <= S_IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      a_q <= '0;
      cs_q <= CS_IDLE;
      wd_q <= '0;
      rdata <= '0;
    end else begin
      st <= st_nxt;
      cnt <= st == S_STROBE ? cnt + CW'(1) : '0;
      if (st == S_IDLE && start) begin
        wr_q <= wr;
        a_q <= addr;
        cs_q <= cs;
        wd_q <= wdata;
      end
      if (st == S_STROBE && last && !wr_q) rdata <= bus.bD;
    end
  // Outputs decode straight from state so reset releases strobes and bus at once
  assign done = st == S_HOLD;
  assign bus.oRd = !(st == S_STROBE && !wr_q);
  assign bus.oWr = !(st == S_STROBE && wr_q);
  assign bus.oCS = st == S_IDLE ? CS_IDLE : cs_q;
  assign bus.oA = st == S_IDLE ? 2'b00 : a_q;
  assign bus.bd_oe = wr_q && st != S_IDLE;
  assign bus.bd_out = wd_q;
endmodule

// File: rtl/prd_poll_ctrl.sv
// prd_poll_ctrl: periodic poll master that reads, validates and refreshes each command board
module prd_poll_ctrl import prd_bus_pkg::*; #(
  parameter int NUM_BOARDS = 2,
  parameter logic [3:0] CS_BASE = 4'b1011,
  parameter logic [3:0] CS_IDLE = 4'b0000,
  parameter logic [7:0] PASSWORD = 8'hA4,
  parameter int STROBE_CLK = 2,
  parameter int POLL_PERIOD = 2000
) (
  input logic clk,
  input logic iRes,
  prd_poll_ctrl_if.master bus,
  input logic [16*NUM_BOARDS-1:0] iInd,
  input logic [NUM_BOARDS-1:0] iTestEn,
  output logic [16*NUM_BOARDS-1:0] oCom,
  output logic [NUM_BOARDS-1:0] oValid,
  output logic [NUM_BOARDS-1:0] oErr,
  output logic [7*NUM_BOARDS-1:0] oVer,
  output logic oBusy
);
  localparam int BW = NUM_BOARDS > 1 ? $clog2(NUM_BOARDS) : 1;
  localparam int PW = $clog2(POLL_PERIOD);
  poll_t phase, phase_nxt;
  op_t op, nop;
  logic [BW-1:0] board, nbrd;
  logic [PW-1:0] cnt;
  logic req_q, req, start, last, done, ok_acc, ok_all;
  logic [15:0] rdata, com_acc;
  logic [4:0] lo, hi;
  assign req = req_q || cnt == '0;
  assign lo = dec_byte(rdata[7:0]);
  assign hi = dec_byte(rdata[15:8]);
  assign ok_all = ok_acc && rdata[15:8] == PASSWORD;
  assign oBusy = phase != P_IDLE;
  // nop/nbrd name the access launched by start
  always_comb begin
    last = op == OP_WR_TEST && board == BW'(NUM_BOARDS - 1);
    start = (phase == P_IDLE && req) || (phase == P_NEXT && !last);
    nop = phase == P_IDLE || op == OP_WR_TEST ? OP_RD_COM0 : op_t'(op + 3'd1);
    nbrd = phase == P_IDLE ? '0 : op == OP_WR_TEST ? BW'(board + 1) : board;
    phase_nxt = start ? P_ACCESS : phase == P_ACCESS && done ? P_NEXT : phase == P_NEXT ? P_IDLE : phase;
  end
  prd_bus_access #(.STROBE_CLK(STROBE_CLK), .CS_IDLE(CS_IDLE)) u_acc (
    .clk,
    .iRes,
    .start,
    .wr(nop == OP_WR_IND || nop == OP_WR_TEST),
    .addr(op_addr(nop)),
    .cs(CS_BASE + 4'(nbrd)),
    .wdata(nop == OP_WR_IND ? iInd[16*nbrd +: 16] : {15'b0, iTestEn[nbrd]}),
    .done,
    .rdata,
    .bus
  );
  always_ff @(posedge clk or negedge iRes)
    if (!iRes) begin
      phase <= P_IDLE;
      op <= OP_RD_COM0;
      board <= '0;
      cnt <= '0;
      req_q <= 1'b0;
      com_acc <= '0;
      ok_acc <= 1'b0;
      oCom <= '0;
      oValid <= '0;
      oErr <= '0;
      oVer <= '0;
    end else begin
      phase <= phase_nxt;
      cnt <= cnt == PW'(POLL_PERIOD - 1) ? '0 : cnt + PW'(1);
      req_q <= phase != P_IDLE && req;
      if (start) begin
        op <= nop;
        board <= nbrd;
      end
      if (done && op == OP_RD_COM0) begin
        com_acc[7:0] <= {hi[3:0], lo[3:0]};
        ok_acc <= hi[4] && lo[4];
      end
      if (done && op == OP_RD_COM1) begin
        com_acc[15:8] <= {hi[3:0], lo[3:0]};
        ok_acc <= ok_acc && hi[4] && lo[4];
      end
      // A failed poll flags the board but keeps its last good command and version
      if (done && op == OP_RD_ID) begin
        oValid[board] <= ok_all;
        oErr[board] <= !ok_all;
        if (ok_all) begin
          oCom[16*board +: 16] <= com_acc;
          oVer[7*board +: 7] <= rdata[7:1];
        end
      end
    end
endmodule

// File: tb/tb_prd_poll_ctrl.sv
// tb_prd_poll_ctrl: scoreboard bench with two command-board models on the backplane
module tb_prd_poll_ctrl;
  typedef struct packed {
    logic [15:0] com;
    logic v;
    logic e;
    logic [6:0] ver;
    logic [15:0] ind;
    logic ten;
  } exp_t;
  logic clk = 1'b0;
  logic iRes = 1'b0;
  logic [31:0] iInd;
  logic [1:0] iTestEn;
  logic [31:0] oCom;
  logic [1:0] oValid, oErr;
  logic [13:0] oVer;
  logic oBusy;
  logic [15:0] m_com [2];
  logic [6:0] m_ver [2];
  logic [7:0] m_pw [2];
  logic m_bad [2];
  logic [15:0] w_ind [2];
  logic [15:0] w_tst [2];
  logic [15:0] prev_com [2];
  logic [6:0] prev_ver [2];
  logic clr_wr = 1'b1;
  int cyc = 0, errors = 0, checks = 0, contend = 0, rd_drv = 0, rd_cyc = 0;
  int rise = 0, last_rise = -1;
  exp_t sb[$];

  prd_poll_ctrl_if bus();
  prd_poll_ctrl dut (.clk, .iRes, .bus, .iInd, .iTestEn, .oCom, .oValid, .oErr, .oVer, .oBusy);

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [3:0] n);
    return {~n, n};
  endfunction

  always_comb begin
    bus.slv_oe = 1'b0;
    bus.slv_out = '0;
    for (int k = 0; k < 2; k++)
      if (!bus.oRd && bus.oCS == 4'(11 + k)) begin
        bus.slv_oe = 1'b1;
        bus.slv_out = bus.oA == 2'b00 ? {enc(m_com[k][7:4]), m_bad[k] ? 8'h33 : enc(m_com[k][3:0])} :
                      bus.oA == 2'b01 ? {enc(m_com[k][15:12]), enc(m_com[k][11:8])} :
                      bus.oA == 2'b11 ? {m_pw[k], m_ver[k], 1'b0} : w_ind[k];
      end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (clr_wr) begin
        w_ind[k] <= 16'hDEAD;
        w_tst[k] <= 16'hDEAD;
      end else if (!bus.oWr && bus.oCS == 4'(11 + k)) begin
        if (bus.oA == 2'b10) w_ind[k] <= bus.bD;
        else if (bus.oA == 2'b11) w_tst[k] <= bus.bD;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.bd_oe && bus.slv_oe) contend <= contend + 1;
    if (!bus.oRd) begin
      rd_cyc <= rd_cyc + 1;
      if (bus.bd_oe) rd_drv <= rd_drv + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_writes();
    clr_wr = 1'b1;
    @(negedge clk);
    clr_wr = 1'b0;
  endtask

  task automatic expect_poll();
    exp_t e;
    logic ok;
    for (int k = 0; k < 2; k++) begin
      ok = !m_bad[k] && m_pw[k] == 8'hA4;
      if (ok) begin
        prev_com[k] = m_com[k];
        prev_ver[k] = m_ver[k];
      end
      e.com = prev_com[k];
      e.v = ok;
      e.e = !ok;
      e.ver = prev_ver[k];
      e.ind = iInd[16*k +: 16];
      e.ten = iTestEn[k];
      sb.push_back(e);
    end
  endtask

  task automatic await_rise();
    int n;
    n = 0;
    while (!oBusy && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check("poll_start", oBusy, 1);
    rise = cyc;
    check("start_cs", bus.oCS, 4'b1011);
    check("start_a", bus.oA, 0);
  endtask

  task automatic finish_poll();
    exp_t e;
    int n;
    n = 0;
    while (oBusy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("poll_end", oBusy, 0);
    check("busy_len", cyc - rise, 50);
    if (last_rise >= 0) check("poll_interval", rise - last_rise, 2000);
    last_rise = rise;
    for (int k = 0; k < 2; k++) begin
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        check($sformatf("com%0d", k), oCom[16*k +: 16], e.com);
        check($sformatf("valid%0d", k), oValid[k], e.v);
        check($sformatf("err%0d", k), oErr[k], e.e);
        check($sformatf("ver%0d", k), oVer[7*k +: 7], e.ver);
        check($sformatf("wr_ind%0d", k), w_ind[k], e.ind);
        check($sformatf("wr_test%0d", k), w_tst[k], {15'b0, e.ten});
      end
    end
  endtask

  initial begin
    m_com = '{16'h0000, 16'h1234};
    m_ver = '{7'h25, 7'h11};
    m_pw = '{8'hA4, 8'hA4};
    m_bad = '{1'b0, 1'b0};
    prev_com = '{16'h0, 16'h0};
    prev_ver = '{7'h0, 7'h0};
    iInd = {16'h8001, 16'h7E18};
    iTestEn = 2'b10;
    repeat (3) @(negedge clk);
    check("rst_rd", bus.oRd, 1);
    check("rst_wr", bus.oWr, 1);
    check("rst_cs", bus.oCS, 4'b0000);
    check("rst_a", bus.oA, 0);
    check("rst_drive", bus.bd_oe, 0);
    check("rst_com", oCom, 0);
    check("rst_valid", oValid, 0);
    check("rst_err", oErr, 0);
    check("rst_ver", oVer, 0);
    check("rst_busy", oBusy, 0);
    expect_poll();
    clr_wr = 1'b0;
    iRes = 1'b1;
    @(negedge clk);
    rise = cyc;
    check("c1_cs", bus.oCS, 4'b1011);
    check("c1_a", bus.oA, 0);
    check("c1_rd", bus.oRd, 1);
    check("c1_busy", oBusy, 1);
    @(negedge clk);
    check("c2_rd", bus.oRd, 0);
    @(negedge clk);
    check("c3_rd", bus.oRd, 0);
    @(negedge clk);
    check("c4_hold_rd", bus.oRd, 1);
    check("c4_hold_cs", bus.oCS, 4'b1011);
    @(negedge clk);
    check("c5_next_cs", bus.oCS, 4'b0000);
    @(negedge clk);
    check("c6_cs", bus.oCS, 4'b1011);
    check("c6_a", bus.oA, 1);
    finish_poll();

    m_com[0] = 16'hA5C3;
    iInd = {16'h8001, 16'h0F0F};
    clear_writes();
    expect_poll();
    await_rise();
    finish_poll();

    m_bad[0] = 1'b1;
    iInd = {16'h55AA, 16'h0001};
    iTestEn = 2'b01;
    clear_writes();
    expect_poll();
    await_rise();
    finish_poll();

    m_bad[0] = 1'b0;
    m_pw[1] = 8'h5A;
    m_com[1] = 16'hFFFF;
    iTestEn = 2'b11;
    clear_writes();
    expect_poll();
    await_rise();
    finish_poll();

    m_pw[1] = 8'hA4;
    m_com[0] = 16'h0F0F;
    clear_writes();
    await_rise();
    while (cyc < rise + 16) @(negedge clk);
    check("op3_strobe_wr", bus.oWr, 0);
    check("op3_strobe_drive", bus.bd_oe, 1);
    #1 iRes = 1'b0;
    #1;
    check("mid_rst_wr", bus.oWr, 1);
    check("mid_rst_drive", bus.bd_oe, 0);
    check("mid_rst_valid", oValid, 0);
    check("mid_rst_busy", oBusy, 0);
    prev_com = '{16'h0, 16'h0};
    prev_ver = '{7'h0, 7'h0};
    @(negedge clk);
    clear_writes();
    expect_poll();
    last_rise = -1;
    iRes = 1'b1;
    @(negedge clk);
    rise = cyc;
    check("restart_cs", bus.oCS, 4'b1011);
    check("restart_a", bus.oA, 0);
    check("restart_busy", oBusy, 1);
    finish_poll();

    check("contention", contend, 0);
    check("read_bus_driven", rd_drv, 0);
    check("read_strobes_seen", rd_cyc != 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
